// File: rtl/axi_arb_pkg.sv
// -----------------------------------------------------------------------------
// axi_arb_pkg
// Shared types and constants for the two-master AXI4-Lite arbiter:
//   wr_state_t / rd_state_t : grant FSM encodings for the write and read paths
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   STATS_W                 : width of the optional grant counters
//   sat_inc()               : saturating increment used by those counters
// -----------------------------------------------------------------------------
package axi_arb_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STATS_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + STATS_W'(1);
  endfunction

endpackage

// File: rtl/axi_rr_arb2.sv
// -----------------------------------------------------------------------------
// axi_rr_arb2
// Two-way round-robin picker. Purely combinational; the caller registers the
// chosen index and keeps the last-grant pointer.
//   req_i[1:0]    : request from port 0 / port 1
//   last_grant_i  : index of the port served most recently
//   en_i          : picker may grant this cycle (caller is idle)
//   grant_o       : chosen port index
//   grant_valid_o : a grant is being offered this cycle
// -----------------------------------------------------------------------------
module axi_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  input  logic       en_i,
  output logic       grant_o,
  output logic       grant_valid_o
);

  assign grant_valid_o = en_i & (|req_i);

  // On contention the port that was not served last wins; otherwise the
  // single requester wins (req_i[1] is 0 when only port 0 asks).
  assign grant_o = (&req_i) ? ~last_grant_i : req_i[1];

endmodule

// File: rtl/axi_lite_arbiter.sv
// -----------------------------------------------------------------------------
// axi_lite_arbiter
// Shares one AXI4-Lite target port between two masters (s0, s1). Write and
// read paths each have an independent round-robin grant FSM and allow one
// outstanding transaction. Once a port is granted, its channels are passed
// through combinationally; the other port sees ready/valid held low.
//
// Ports:
//   axi_aclk, axi_aresetn    : clock, asynchronous active-low reset
//   s0_axi_* / s1_axi_*      : slave-side AW, W, B, AR, R channels per master
//   m_axi_*                  : master-side AW, W, B, AR, R channels to target
//   wr_grant_cnt0/1,
//   rd_grant_cnt0/1          : saturating per-port grant counters, present
//                              only when AXI_ARB_STATS_EN is defined
// -----------------------------------------------------------------------------
module axi_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,  // multiple of 8
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    axi_aclk,
  input  logic                    axi_aresetn,
  // master 0
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [1:0]              s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [1:0]              s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready,
  // master 1
  input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
  input  logic                    s1_axi_awvalid,
  output logic                    s1_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
  input  logic                    s1_axi_wvalid,
  output logic                    s1_axi_wready,
  output logic [1:0]              s1_axi_bresp,
  output logic                    s1_axi_bvalid,
  input  logic                    s1_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
  input  logic                    s1_axi_arvalid,
  output logic                    s1_axi_arready,
  output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
  output logic [1:0]              s1_axi_rresp,
  output logic                    s1_axi_rvalid,
  input  logic                    s1_axi_rready,
  // shared target
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
`ifdef AXI_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]      wr_grant_cnt0,
  output logic [STATS_W-1:0]      wr_grant_cnt1,
  output logic [STATS_W-1:0]      rd_grant_cnt0,
  output logic [STATS_W-1:0]      rd_grant_cnt1
`endif
);

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  wr_state_t w_state_q;
  logic      w_gnt_q, w_last_q, aw_done_q, w_done_q;
  logic      w_pick, w_pick_vld;
  logic      w_xfer, w_resp, aw_hs, w_hs, b_hs;

  axi_rr_arb2 u_wr_arb (
    .req_i         ({s1_axi_awvalid, s0_axi_awvalid}),
    .last_grant_i  (w_last_q),
    .en_i          (w_state_q == W_IDLE),
    .grant_o       (w_pick),
    .grant_valid_o (w_pick_vld)
  );

  assign w_xfer = (w_state_q == W_XFER);
  assign w_resp = (w_state_q == W_RESP);

  // NOTE: every output is qualified by the FSM state, so an asynchronous
  // reset (which forces IDLE) zeroes the outputs in the same cycle without
  // needing its own reset path.
  assign m_axi_awvalid = w_xfer & ~aw_done_q & (w_gnt_q ? s1_axi_awvalid : s0_axi_awvalid);
  assign m_axi_awaddr  = w_xfer ? (w_gnt_q ? s1_axi_awaddr : s0_axi_awaddr) : '0;
  assign m_axi_wvalid  = w_xfer & ~w_done_q & (w_gnt_q ? s1_axi_wvalid : s0_axi_wvalid);
  assign m_axi_wdata   = w_xfer ? (w_gnt_q ? s1_axi_wdata : s0_axi_wdata) : '0;
  assign m_axi_wstrb   = w_xfer ? (w_gnt_q ? s1_axi_wstrb : s0_axi_wstrb) : '0;
  assign m_axi_bready  = w_resp & (w_gnt_q ? s1_axi_bready : s0_axi_bready);

  assign s0_axi_awready = w_xfer & ~aw_done_q & ~w_gnt_q & m_axi_awready;
  assign s1_axi_awready = w_xfer & ~aw_done_q &  w_gnt_q & m_axi_awready;
  assign s0_axi_wready  = w_xfer & ~w_done_q  & ~w_gnt_q & m_axi_wready;
  assign s1_axi_wready  = w_xfer & ~w_done_q  &  w_gnt_q & m_axi_wready;
  assign s0_axi_bvalid  = w_resp & ~w_gnt_q & m_axi_bvalid;
  assign s1_axi_bvalid  = w_resp &  w_gnt_q & m_axi_bvalid;
  assign s0_axi_bresp   = (w_resp & ~w_gnt_q) ? m_axi_bresp : RESP_OKAY;
  assign s1_axi_bresp   = (w_resp &  w_gnt_q) ? m_axi_bresp : RESP_OKAY;

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid  & m_axi_wready;
  assign b_hs  = m_axi_bvalid  & m_axi_bready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      w_state_q <= W_IDLE;
      w_gnt_q   <= 1'b0;
      w_last_q  <= 1'b1;   // s0 wins the first contention
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (w_pick_vld) begin
            w_gnt_q   <= w_pick;
            w_state_q <= W_XFER;
          end
        end
        W_XFER: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          // AW and W may complete in either order or together.
          if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) w_state_q <= W_RESP;
        end
        W_RESP: begin
          if (b_hs) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            w_last_q  <= w_gnt_q;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  rd_state_t r_state_q;
  logic      r_gnt_q, r_last_q;
  logic      r_pick, r_pick_vld;
  logic      r_addr, r_data, ar_hs, r_hs;

  axi_rr_arb2 u_rd_arb (
    .req_i         ({s1_axi_arvalid, s0_axi_arvalid}),
    .last_grant_i  (r_last_q),
    .en_i          (r_state_q == R_IDLE),
    .grant_o       (r_pick),
    .grant_valid_o (r_pick_vld)
  );

  assign r_addr = (r_state_q == R_ADDR);
  assign r_data = (r_state_q == R_DATA);

  assign m_axi_arvalid = r_addr & (r_gnt_q ? s1_axi_arvalid : s0_axi_arvalid);
  assign m_axi_araddr  = r_addr ? (r_gnt_q ? s1_axi_araddr : s0_axi_araddr) : '0;
  assign m_axi_rready  = r_data & (r_gnt_q ? s1_axi_rready : s0_axi_rready);

  assign s0_axi_arready = r_addr & ~r_gnt_q & m_axi_arready;
  assign s1_axi_arready = r_addr &  r_gnt_q & m_axi_arready;
  assign s0_axi_rvalid  = r_data & ~r_gnt_q & m_axi_rvalid;
  assign s1_axi_rvalid  = r_data &  r_gnt_q & m_axi_rvalid;
  assign s0_axi_rdata   = (r_data & ~r_gnt_q) ? m_axi_rdata : '0;
  assign s1_axi_rdata   = (r_data &  r_gnt_q) ? m_axi_rdata : '0;
  assign s0_axi_rresp   = (r_data & ~r_gnt_q) ? m_axi_rresp : RESP_OKAY;
  assign s1_axi_rresp   = (r_data &  r_gnt_q) ? m_axi_rresp : RESP_OKAY;

  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs  = m_axi_rvalid  & m_axi_rready;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state_q <= R_IDLE;
      r_gnt_q   <= 1'b0;
      r_last_q  <= 1'b1;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (r_pick_vld) begin
            r_gnt_q   <= r_pick;
            r_state_q <= R_ADDR;
          end
        end
        R_ADDR: if (ar_hs) r_state_q <= R_DATA;
        R_DATA: begin
          if (r_hs) begin
            r_last_q  <= r_gnt_q;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

`ifdef AXI_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Grant statistics: one count per IDLE-to-grant transition, per port.
  // ---------------------------------------------------------------------------
  logic [STATS_W-1:0] wr_cnt0_q, wr_cnt1_q, rd_cnt0_q, rd_cnt1_q;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_cnt0_q <= '0;
      wr_cnt1_q <= '0;
      rd_cnt0_q <= '0;
      rd_cnt1_q <= '0;
    end else begin
      if (w_pick_vld) begin
        if (w_pick) wr_cnt1_q <= sat_inc(wr_cnt1_q);
        else        wr_cnt0_q <= sat_inc(wr_cnt0_q);
      end
      if (r_pick_vld) begin
        if (r_pick) rd_cnt1_q <= sat_inc(rd_cnt1_q);
        else        rd_cnt0_q <= sat_inc(rd_cnt0_q);
      end
    end
  end

  assign wr_grant_cnt0 = wr_cnt0_q;
  assign wr_grant_cnt1 = wr_cnt1_q;
  assign rd_grant_cnt0 = rd_cnt0_q;
  assign rd_grant_cnt1 = rd_cnt1_q;
`endif

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_arbiter
// Directed bench for axi_lite_arbiter. A table of transaction vectors is run
// through a cycle loop that plays both masters and a simple target; the
// expected order, addresses, data and responses come from the table. Hand
// sequences cover reset state, reset mid-transfer and the grant counters
// (the latter only when AXI_ARB_STATS_EN is defined).
// -----------------------------------------------------------------------------
module tb_axi_lite_arbiter;
  import axi_arb_pkg::*;

  logic clk, rst_n;

  logic [7:0]  s_awaddr [2];
  logic        s_awvalid[2], s_awready[2];
  logic [31:0] s_wdata  [2];
  logic [3:0]  s_wstrb  [2];
  logic        s_wvalid [2], s_wready [2];
  logic [1:0]  s_bresp  [2];
  logic        s_bvalid [2], s_bready [2];
  logic [7:0]  s_araddr [2];
  logic        s_arvalid[2], s_arready[2];
  logic [31:0] s_rdata  [2];
  logic [1:0]  s_rresp  [2];
  logic        s_rvalid [2], s_rready [2];

  logic [7:0]  m_awaddr, m_araddr;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;
`ifdef AXI_ARB_STATS_EN
  logic [15:0] wr_cnt0, wr_cnt1, rd_cnt0, rd_cnt1;
`endif

  axi_lite_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .s0_axi_awaddr(s_awaddr[0]), .s0_axi_awvalid(s_awvalid[0]), .s0_axi_awready(s_awready[0]),
    .s0_axi_wdata(s_wdata[0]), .s0_axi_wstrb(s_wstrb[0]), .s0_axi_wvalid(s_wvalid[0]),
    .s0_axi_wready(s_wready[0]), .s0_axi_bresp(s_bresp[0]), .s0_axi_bvalid(s_bvalid[0]),
    .s0_axi_bready(s_bready[0]), .s0_axi_araddr(s_araddr[0]), .s0_axi_arvalid(s_arvalid[0]),
    .s0_axi_arready(s_arready[0]), .s0_axi_rdata(s_rdata[0]), .s0_axi_rresp(s_rresp[0]),
    .s0_axi_rvalid(s_rvalid[0]), .s0_axi_rready(s_rready[0]),
    .s1_axi_awaddr(s_awaddr[1]), .s1_axi_awvalid(s_awvalid[1]), .s1_axi_awready(s_awready[1]),
    .s1_axi_wdata(s_wdata[1]), .s1_axi_wstrb(s_wstrb[1]), .s1_axi_wvalid(s_wvalid[1]),
    .s1_axi_wready(s_wready[1]), .s1_axi_bresp(s_bresp[1]), .s1_axi_bvalid(s_bvalid[1]),
    .s1_axi_bready(s_bready[1]), .s1_axi_araddr(s_araddr[1]), .s1_axi_arvalid(s_arvalid[1]),
    .s1_axi_arready(s_arready[1]), .s1_axi_rdata(s_rdata[1]), .s1_axi_rresp(s_rresp[1]),
    .s1_axi_rvalid(s_rvalid[1]), .s1_axi_rready(s_rready[1]),
    .m_axi_awaddr(m_awaddr), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wvalid(m_wvalid), .m_axi_wready(m_wready),
    .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid), .m_axi_bready(m_bready),
    .m_axi_araddr(m_araddr), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready)
`ifdef AXI_ARB_STATS_EN
    , .wr_grant_cnt0(wr_cnt0), .wr_grant_cnt1(wr_cnt1)
    , .rd_grant_cnt0(rd_cnt0), .rd_grant_cnt1(rd_cnt1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Vector record: what each master requests, what the target answers, and the
  // hand-computed port expected to be served first on each path.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  wr_req;
    logic [1:0]  rd_req;
    logic [7:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          aw_delay;
    logic        wr_first;
    logic        rd_first;
  } vec_t;

  // Environment state (masters + target).
  bit          aw_pend[2], w_pend[2], ar_pend[2], port_seen[2];
  int          b_cnt[2], r_cnt[2], exp_b[2], exp_r[2];
  logic [1:0]  b_resp[2], r_resp[2];
  logic [31:0] r_data[2];
  bit          t_aw_got, t_w_got, t_ar_got, t_stall;
  int          t_aw_wait, t_aw_delay;
  logic [1:0]  t_resp;
  logic [31:0] t_rdata;
  logic [7:0]  aw_q[$], ar_q[$];
  logic [31:0] w_q[$];
  logic [3:0]  strb_q[$];
  int          first_aw_cyc, aw_hs_cyc, w_hs_cyc, bad_resp;
  int          n_cmp, n_err;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 2; p++) begin
      s_awaddr[p] = '0; s_awvalid[p] = 1'b0; s_wdata[p] = '0; s_wstrb[p] = '0;
      s_wvalid[p] = 1'b0; s_bready[p] = 1'b1; s_araddr[p] = '0; s_arvalid[p] = 1'b0;
      s_rready[p] = 1'b1;
    end
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0;
  endtask

  task automatic clear_env();
    for (int p = 0; p < 2; p++) begin
      aw_pend[p] = 0; w_pend[p] = 0; ar_pend[p] = 0; port_seen[p] = 0;
      b_cnt[p] = 0; r_cnt[p] = 0; exp_b[p] = 0; exp_r[p] = 0;
      b_resp[p] = 'x; r_resp[p] = 'x; r_data[p] = 'x;
    end
    t_aw_got = 0; t_w_got = 0; t_ar_got = 0; t_stall = 0;
    t_aw_wait = 0; t_aw_delay = 0; t_resp = RESP_OKAY; t_rdata = '0;
    aw_q.delete(); ar_q.delete(); w_q.delete(); strb_q.delete();
    first_aw_cyc = -1; aw_hs_cyc = -1; w_hs_cyc = -1; bad_resp = 0;
  endtask

  // One iteration per clock: drive at the falling edge, let the DUT settle,
  // then record every handshake that the next rising edge will complete.
  task automatic run_env(input int max_cyc, output bit done);
    bit all;
    done = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        s_awvalid[p] = aw_pend[p];
        s_wvalid[p]  = w_pend[p];
        s_arvalid[p] = ar_pend[p];
      end
      m_awready = !t_stall && !t_aw_got && (t_aw_wait >= t_aw_delay);
      m_wready  = !t_stall && !t_w_got;
      m_bvalid  = !t_stall && t_aw_got && t_w_got;
      m_bresp   = m_bvalid ? t_resp : 2'b00;
      m_arready = !t_stall && !t_ar_got;
      m_rvalid  = !t_stall && t_ar_got;
      m_rdata   = m_rvalid ? t_rdata : '0;
      m_rresp   = m_rvalid ? t_resp : 2'b00;
      #1;
      if (m_awvalid && first_aw_cyc < 0) first_aw_cyc = c;
      if (m_bready && !(t_aw_got && t_w_got)) bad_resp++;
      for (int p = 0; p < 2; p++)
        port_seen[p] |= s_awready[p] | s_wready[p] | s_bvalid[p] | s_arready[p] | s_rvalid[p];
      // target side
      if (m_awvalid && m_awready) begin
        aw_q.push_back(m_awaddr); t_aw_got = 1; t_aw_wait = 0; aw_hs_cyc = c;
      end else if (m_awvalid) t_aw_wait++;
      if (m_wvalid && m_wready) begin
        w_q.push_back(m_wdata); strb_q.push_back(m_wstrb); t_w_got = 1; w_hs_cyc = c;
      end
      if (m_bvalid && m_bready) begin t_aw_got = 0; t_w_got = 0; end
      if (m_arvalid && m_arready) begin ar_q.push_back(m_araddr); t_ar_got = 1; end
      if (m_rvalid && m_rready) t_ar_got = 0;
      // master side (bready/rready held high)
      for (int p = 0; p < 2; p++) begin
        if (s_awvalid[p] && s_awready[p]) aw_pend[p] = 0;
        if (s_wvalid[p]  && s_wready[p])  w_pend[p]  = 0;
        if (s_arvalid[p] && s_arready[p]) ar_pend[p] = 0;
        if (s_bvalid[p]) begin b_cnt[p]++; b_resp[p] = s_bresp[p]; end
        if (s_rvalid[p]) begin r_cnt[p]++; r_data[p] = s_rdata[p]; r_resp[p] = s_rresp[p]; end
      end
      all = !(t_aw_got || t_w_got || t_ar_got);
      for (int p = 0; p < 2; p++)
        if (aw_pend[p] || w_pend[p] || ar_pend[p] || b_cnt[p] != exp_b[p] || r_cnt[p] != exp_r[p])
          all = 0;
      if (all) begin
        done = 1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit done;
    int nw, nr;
    clear_env();
    s_awaddr[0] = v.addr0; s_araddr[0] = v.addr0; s_wdata[0] = v.wdata0; s_wstrb[0] = 4'hF;
    s_awaddr[1] = v.addr1; s_araddr[1] = v.addr1; s_wdata[1] = v.wdata1; s_wstrb[1] = 4'h3;
    for (int p = 0; p < 2; p++) begin
      aw_pend[p] = v.wr_req[p]; w_pend[p] = v.wr_req[p]; ar_pend[p] = v.rd_req[p];
      exp_b[p] = int'(v.wr_req[p]); exp_r[p] = int'(v.rd_req[p]);
    end
    t_resp = v.resp; t_rdata = v.rdata; t_aw_delay = v.aw_delay;
    nw = int'(v.wr_req[0]) + int'(v.wr_req[1]);
    nr = int'(v.rd_req[0]) + int'(v.rd_req[1]);
    run_env(40, done);
    check({tag, " done"}, 32'(done), 1);
    check({tag, " aw beats"}, aw_q.size(), nw);
    check({tag, " w beats"}, w_q.size(), nw);
    check({tag, " ar beats"}, ar_q.size(), nr);
    check({tag, " resp before both hs"}, bad_resp, 0);
    if (nw > 0 && aw_q.size() > 0 && w_q.size() > 0) begin
      check({tag, " aw latency"}, first_aw_cyc, 1);
      check({tag, " aw first"}, aw_q[0], v.wr_first ? v.addr1 : v.addr0);
      check({tag, " w first"}, w_q[0], v.wr_first ? v.wdata1 : v.wdata0);
      check({tag, " wstrb first"}, strb_q[0], v.wr_first ? 4'h3 : 4'hF);
    end
    if (nw == 2 && aw_q.size() == 2)
      check({tag, " aw second"}, aw_q[1], v.wr_first ? v.addr0 : v.addr1);
    if (nr > 0 && ar_q.size() > 0)
      check({tag, " ar first"}, ar_q[0], v.rd_first ? v.addr1 : v.addr0);
    if (nr == 2 && ar_q.size() == 2)
      check({tag, " ar second"}, ar_q[1], v.rd_first ? v.addr0 : v.addr1);
    if (v.aw_delay > 0)
      check({tag, " aw/w skew"}, aw_hs_cyc - w_hs_cyc, v.aw_delay);
    for (int p = 0; p < 2; p++) begin
      string ps;
      ps = $sformatf("%s s%0d", tag, p);
      if (v.wr_req[p]) begin
        check({ps, " b count"}, b_cnt[p], 1);
        check({ps, " bresp"}, b_resp[p], v.resp);
      end
      if (v.rd_req[p]) begin
        check({ps, " r count"}, r_cnt[p], 1);
        check({ps, " rdata"}, r_data[p], v.rdata);
        check({ps, " rresp"}, r_resp[p], v.resp);
      end
      if (!v.wr_req[p] && !v.rd_req[p])
        check({ps, " idle port quiet"}, 32'(port_seen[p]), 0);
    end
  endtask

  vec_t vecs[8];

  initial begin
    bit done;
    vec_t v;
    n_cmp = 0;
    n_err = 0;

    //           wr     rd     a0     a1     wd0            wd1            rdata          resp         dly wf rf
    vecs[0] = '{2'b01, 2'b00, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0,        32'h0,        RESP_OKAY,   0, 0, 0}; // single s0 write
    vecs[1] = '{2'b10, 2'b00, 8'h00, 8'h14, 32'h0,        32'hCAFE0001, 32'h0,        RESP_SLVERR, 0, 1, 0}; // s1 write, error resp
    vecs[2] = '{2'b11, 2'b00, 8'h04, 8'h08, 32'h11111111, 32'h22222222, 32'h0,        RESP_OKAY,   0, 0, 0}; // contention
    vecs[3] = '{2'b11, 2'b00, 8'h0C, 8'h18, 32'h33333333, 32'h44444444, 32'h0,        RESP_OKAY,   0, 0, 0}; // contention again
    vecs[4] = '{2'b01, 2'b00, 8'h40, 8'h00, 32'h5555AAAA, 32'h0,        32'h0,        RESP_OKAY,   3, 0, 0}; // W 3 cycles ahead of AW
    vecs[5] = '{2'b01, 2'b10, 8'h20, 8'h30, 32'h0BADF00D, 32'h0,        32'h12345678, RESP_OKAY,   0, 0, 1}; // concurrent wr/rd
    vecs[6] = '{2'b00, 2'b10, 8'h00, 8'h34, 32'h0,        32'h0,        32'h0,        RESP_SLVERR, 0, 0, 1}; // read error
    vecs[7] = '{2'b00, 2'b11, 8'h50, 8'h54, 32'h0,        32'h0,        32'h87654321, RESP_OKAY,   0, 0, 0}; // read contention

    // Reset state, with live-looking inputs that must not leak through.
    clear_env();
    idle_inputs();
    rst_n = 1'b0;
    s_awvalid[0] = 1'b1; s_wvalid[0] = 1'b1; s_awaddr[0] = 8'hAA; s_wdata[0] = 32'hFFFF0000;
    s_arvalid[1] = 1'b1; s_araddr[1] = 8'h55;
    m_bvalid = 1'b1; m_bresp = RESP_SLVERR; m_rvalid = 1'b1; m_rdata = 32'hA5A5A5A5; m_rresp = RESP_SLVERR;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst m valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    check("rst m addr", {m_awaddr, m_araddr}, 0);
    check("rst m wdata", m_wdata, 0);
    check("rst s0 ctl", {s_awready[0], s_wready[0], s_bvalid[0], s_arready[0], s_rvalid[0],
                         s_bresp[0], s_rresp[0]}, 0);
    check("rst s1 ctl", {s_awready[1], s_wready[1], s_bvalid[1], s_arready[1], s_rvalid[1],
                         s_bresp[1], s_rresp[1]}, 0);
    check("rst s1 rdata", s_rdata[1], 0);
`ifdef AXI_ARB_STATS_EN
    check("rst stats", {wr_cnt0, wr_cnt1, rd_cnt0, rd_cnt1}, 0);
`endif
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a write transfer (and a pending read).
    clear_env();
    s_awaddr[0] = 8'h60; s_wdata[0] = 32'h0F0F0F0F; s_wstrb[0] = 4'hF; s_araddr[1] = 8'h64;
    aw_pend[0] = 1; w_pend[0] = 1; ar_pend[1] = 1; t_stall = 1;
    run_env(3, done);
    check("mid pre-reset valids", {m_awvalid, m_wvalid, m_arvalid}, 3'b111);
    rst_n = 1'b0;
    #1;
    check("mid reset valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
    check("mid reset addr", {m_awaddr, m_araddr}, 0);
    check("mid reset s readies", {s_awready[0], s_wready[0], s_arready[1]}, 0);
    clear_env();
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // After release both FSMs must accept fresh work: 3 s0 writes, 2 s1 reads.
    for (int i = 0; i < 3; i++) begin
      v = '{2'b01, 2'b00, 8'h70 + 8'(4 * i), 8'h00, 32'h1000 + 32'(i), 32'h0, 32'h0,
            RESP_OKAY, 0, 0, 0};
      run_vec(v, $sformatf("post w%0d", i));
    end
    for (int i = 0; i < 2; i++) begin
      v = '{2'b00, 2'b10, 8'h00, 8'h90 + 8'(4 * i), 32'h0, 32'h0, 32'hBEE00000 + 32'(i),
            RESP_OKAY, 0, 0, 1};
      run_vec(v, $sformatf("post r%0d", i));
    end
`ifdef AXI_ARB_STATS_EN
    #1;
    check("stats wr0", wr_cnt0, 3);
    check("stats wr1", wr_cnt1, 0);
    check("stats rd0", rd_cnt0, 0);
    check("stats rd1", rd_cnt1, 2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
